// File: rtl/ex_mem_skid_if.sv
// EX->MEM valid/ready bus. The slave modport is the pipeline stage's view;
// the master modport is the view of the environment that drives EX and consumes on the MEM side.
interface ex_mem_skid_if #(
   parameter int BUS_W = 72
);
   logic             in_valid_i;
   logic             in_ready_o;
   logic [BUS_W-1:0] in_data_i;
   logic             out_valid_o;
   logic             out_ready_i;
   logic [BUS_W-1:0] out_data_o;

   modport slave (
      input  in_valid_i,
      output in_ready_o,
      input  in_data_i,
      output out_valid_o,
      input  out_ready_i,
      output out_data_o
   );

   modport master (
      output in_valid_i,
      input  in_ready_o,
      output in_data_i,
      input  out_valid_o,
      output out_ready_i,
      input  out_data_o
   );
endinterface

// File: rtl/ex_mem_skid.sv
// EX->MEM two-entry skid stage. Latency is one cycle, and in_ready_o is a pure register output (!skid_v), so it never depends on out_ready_i.
// Defining EX_MEM_STALL_CNT_EN builds a 32-bit MEM stall-cycle counter; otherwise stall_cnt_o is tied to zero.
module ex_mem_skid #(
   parameter int BUS_W = 72
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                flush_i,
   ex_mem_skid_if.slave        bus,
   output logic [31:0]         stall_cnt_o
);

   // The state encoding is {main_v, skid_v}, so the valid bits are simply the state bits.
   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ONE   = 2'b10,
      FULL  = 2'b11
   } state_t;

   state_t           state_q, state_d;
   logic [BUS_W-1:0] main_q, main_d;
   logic [BUS_W-1:0] skid_q, skid_d;

   logic main_v, skid_v;
   logic accept, drain;

   assign main_v = state_q[1];
   assign skid_v = state_q[0];

   assign bus.in_ready_o  = !skid_v;
   assign bus.out_valid_o = main_v;
   assign bus.out_data_o  = main_q;

   assign accept = bus.in_valid_i & !skid_v;
   assign drain  = main_v & bus.out_ready_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;

      case (state_q)
         EMPTY: begin
            if (accept) begin
               state_d = ONE;
               main_d  = bus.in_data_i;
            end
         end
         ONE: begin
            if (accept && drain) begin
               main_d = bus.in_data_i;
            end else if (accept) begin
               state_d = FULL;
               skid_d  = bus.in_data_i;
            end else if (drain) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            // in_ready_o is low here, so the only possible event is a drain that promotes skid into main.
            if (drain) begin
               state_d = ONE;
               main_d  = skid_q;
            end
         end
         default: begin
            state_d = EMPTY;
         end
      endcase

      // Flush overrides everything. A drain in the same cycle has already been taken by MEM.
      if (flush_i) begin
         state_d = EMPTY;
         main_d  = '0;
         skid_d  = '0;
      end
   end

`ifdef EX_MEM_STALL_CNT_EN
   logic [31:0] stall_q, stall_d;

   // The counter is deliberately insensitive to flush and wraps naturally at 32 bits.
   always_comb begin
      stall_d = stall_q;
      if (main_v && !bus.out_ready_i) begin
         stall_d = stall_q + 32'd1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end

   assign stall_cnt_o = stall_q;
`else
   assign stall_cnt_o = 32'd0;
`endif

endmodule

// File: doc/ex_mem_skid.md
Name: ex_mem_skid

Overview:
- Valid/ready pipeline stage between EX and MEM. It captures the EX result bus and presents it to MEM.
- A two-entry skid buffer lets EX keep issuing while MEM stalls, with no combinational path from out_ready_i to in_ready_o.
- Supports a synchronous pipeline flush on branch/exception redirect.
- Sits directly downstream of the ID/EX register, behind the EX datapath.

Parameters:
- BUS_W, 72, width of the EX→MEM bus (ALU result 32, store data 32, rd 5, mem op 3).

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset; asynchronous, active-high.
- flush_i  input  1  synchronous flush; discards all buffered entries.
- in_valid_i  input  1  EX presents a valid bus.
- in_ready_o  output  1  stage can accept an entry this cycle.
- in_data_i  input  BUS_W  EX→MEM bus.
- out_valid_o  output  1  MEM-side entry valid.
- out_ready_i  input  1  MEM consumes the entry this cycle.
- out_data_o  output  BUS_W  head entry presented to MEM.
- stall_cnt_o  output  32  stall-cycle counter (see Optional Feature).

Behaviour:
- Storage: main register (main_d, main_v) drives out_data_o/out_valid_o. Skid register (skid_d, skid_v) holds overflow.
- State is encoded by (main_v, skid_v):
  - EMPTY = (0,0)
  - ONE = (1,0)
  - FULL = (1,1)
  - (0,1) is illegal and never reached.
- in_ready_o = !skid_v. It is a pure register output, independent of out_ready_i and in_valid_i in the same cycle.
- Define accept = in_valid_i & in_ready_o and drain = main_v & out_ready_i.
- Transitions on the rising edge when flush_i=0:
  - EMPTY: accept → ONE, main_d<=in_data_i. Otherwise stay EMPTY.
  - ONE: accept & drain → ONE, main_d<=in_data_i. accept & !drain → FULL, skid_d<=in_data_i. !accept & drain → EMPTY. Otherwise hold.
  - FULL: drain → ONE, main_d<=skid_d, skid_v<=0. Otherwise hold. accept is impossible because in_ready_o=0.
- Ordering: strict FIFO order. An entry accepted later never overtakes an earlier one.
- Latency: an entry accepted at edge N is visible on out_data_o/out_valid_o after edge N when it lands in main. Throughput is one entry per cycle while out_ready_i=1.
- Data stability: while out_valid_o=1 and out_ready_i=0, out_data_o must not change.
- flush_i:
  - At the next edge, main_v<=0, skid_v<=0, main_d<=0, skid_d<=0, regardless of accept/drain in that cycle.
  - An entry offered in the flush cycle is dropped.
  - A drain in the flush cycle still counts as consumed by MEM; the flush only clears the buffer.
- Reset (asynchronous, any cycle including mid-transfer): main_v=0, skid_v=0, main_d=0, skid_d=0, stall counter=0.
  - Hence out_valid_o=0, out_data_o=0, in_ready_o=1, stall_cnt_o=0.
  - All buffered entries are lost.
- out_valid_o is independent of in_valid_i in the same cycle; there is no bypass from input to output.

Optional Feature:
- Macro: EX_MEM_STALL_CNT_EN.
- Defined:
  - A 32-bit counter increments on each edge where out_valid_o=1 and out_ready_i=0.
  - It wraps 0xFFFFFFFF→0x00000000.
  - It is not cleared by flush_i, only by rst_i.
  - stall_cnt_o reflects the counter.
- Undefined: no counter logic is built and stall_cnt_o is tied to 32'd0.

Test Plan:
- Reset then idle, then in_valid_i=1 with data 0x...A1 and out_ready_i=1 → in_ready_o=1 throughout; out_valid_o=1 with out_data_o=0x...A1 one edge later.
- Back-to-back stream 0x01..0x05 with out_ready_i=1 → outputs 0x01..0x05 in consecutive cycles; in_ready_o stays 1.
- Stream 0x10,0x11,0x12 with out_ready_i=0 → after 2 accepts, in_ready_o=0 and 0x12 is held upstream. Then raise out_ready_i → output order 0x10,0x11,0x12 and in_ready_o returns to 1 after the first drain.
- FULL state (0x20 main, 0x21 skid), assert flush_i one cycle with in_valid_i=1 data 0x22 → next cycle out_valid_o=0, in_ready_o=1, out_data_o=0; 0x22 never appears at the output.
- Assert rst_i asynchronously mid-cycle while in ONE with 0x30 → out_valid_o drops to 0 immediately without a clock edge, in_ready_o=1; after release the stage behaves as from reset.
- With EX_MEM_STALL_CNT_EN: hold out_valid_o=1 and out_ready_i=0 for 7 cycles → stall_cnt_o=7; flush → still 7; rst_i → 0. Without the macro, stall_cnt_o=0 always.
